// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types for the sequential slice comparator
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_INIT = '{eq: 1'b1, gt: 1'b0};

endpackage

// File: rtl/seq_cmp_ctrl_if.sv
// rtl/seq_cmp_ctrl_if.sv - request/result bundle of the sequential comparator
interface seq_cmp_ctrl_if #(
  parameter int W = 32,
  parameter int S = 8
);
  localparam int N  = W / S;
  localparam int SW = $clog2(N) + 1;

  logic          start;
  logic          abort;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          eq;
  logic          gt;
  logic [SW-1:0] steps;

  modport master (
    output start, abort, a, b,
    input  busy, done, eq, gt, steps
  );

  modport slave (
    input  start, abort, a, b,
    output busy, done, eq, gt, steps
  );
endinterface

// File: rtl/cmp_slice.sv
// rtl/cmp_slice.sv - one S-bit magnitude comparator slice with eq/gt cascade
module cmp_slice
  import cmp_pkg::*;
#(
  parameter int S = 8
) (
  input  logic [S-1:0] a_i,
  input  logic [S-1:0] b_i,
  input  cmp_res_t     cas_i,
  output cmp_res_t     res_o
);

  // A more significant slice already decided the result; just forward it.
  always_comb begin
    res_o = cas_i;
    if (cas_i.eq) begin
      res_o.eq = (a_i == b_i);
      res_o.gt = (a_i > b_i);
    end
  end

endmodule

// File: rtl/seq_cmp_ctrl.sv
// rtl/seq_cmp_ctrl.sv - compares two W-bit operands MSB slice first, one slice per cycle
module seq_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int W = 32,
  parameter int S = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_cmp_ctrl_if.slave bus
);

  localparam int N  = W / S;
  localparam int IW = $clog2(N);
  localparam int SW = $clog2(N) + 1;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [IW-1:0] idx_q;
  cmp_res_t      cas_q;
  logic [SW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          eq_q;
  logic          gt_q;
  logic [SW-1:0] steps_q;

  logic [S-1:0]  slice_a;
  logic [S-1:0]  slice_b;
  cmp_res_t      slice_res;

  assign slice_a = a_q[idx_q*S +: S];
  assign slice_b = b_q[idx_q*S +: S];

  cmp_slice #(.S(S)) u_slice (
    .a_i   (slice_a),
    .b_i   (slice_b),
    .cas_i (cas_q),
    .res_o (slice_res)
  );

  // Results are published one cycle after DONE so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= IW'(N - 1);
      cas_q   <= CMP_RES_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b1;
      gt_q    <= 1'b0;
      steps_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            idx_q   <= IW'(N - 1);
            cas_q   <= CMP_RES_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cas_q <= slice_res;
            cnt_q <= cnt_q + SW'(1);
            if (!slice_res.eq || idx_q == '0) begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q - IW'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          eq_q    <= cas_q.eq;
          gt_q    <= cas_q.gt;
          steps_q <= cnt_q;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.eq    = eq_q;
  assign bus.gt    = gt_q;
  assign bus.steps = steps_q;

endmodule

// File: tb/tb_seq_cmp_ctrl.sv
// tb/tb_seq_cmp_ctrl.sv - directed self-checking bench for seq_cmp_ctrl (W=32, S=8)
module tb_seq_cmp_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  seq_cmp_ctrl_if #(.W(32), .S(8)) bus ();

  seq_cmp_ctrl #(.W(32), .S(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start at a negedge, then reports the done latency (cycles after
  // the start edge) and how many done pulses appeared within a bounded window.
  task automatic run_cmp(input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int ndone);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat   = 0;
    ndone = 0;
    if (bus.done) ndone++;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.eq !== 1'b1) begin n_fail++; $display("FAIL reset_eq: got %b want 1", bus.eq); end
    n_tests++; if (bus.gt !== 1'b0) begin n_fail++; $display("FAIL reset_gt: got %b want 0", bus.gt); end
    n_tests++; if (bus.steps !== 3'd0) begin n_fail++; $display("FAIL reset_steps: got %0d want 0", bus.steps); end
  endtask

  task automatic test_equal();
    int lat, nd;
    run_cmp(32'h2E2E2E2E, 32'h2E2E2E2E, lat, nd);
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL equal_latency: got %0d want 5", lat); end
    n_tests++; if (nd != 1) begin n_fail++; $display("FAIL equal_ndone: got %0d want 1", nd); end
    n_tests++; if ({bus.eq, bus.gt} !== 2'b10) begin n_fail++; $display("FAIL equal_eqgt: got %b want 10", {bus.eq, bus.gt}); end
    n_tests++; if (bus.steps !== 3'd4) begin n_fail++; $display("FAIL equal_steps: got %0d want 4", bus.steps); end
  endtask

  task automatic test_msb_early();
    int lat, nd;
    run_cmp(32'h80000000, 32'h7FFFFFFF, lat, nd);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL msb_latency: got %0d want 2", lat); end
    n_tests++; if (nd != 1) begin n_fail++; $display("FAIL msb_ndone: got %0d want 1", nd); end
    n_tests++; if ({bus.eq, bus.gt} !== 2'b01) begin n_fail++; $display("FAIL msb_eqgt: got %b want 01", {bus.eq, bus.gt}); end
    n_tests++; if (bus.steps !== 3'd1) begin n_fail++; $display("FAIL msb_steps: got %0d want 1", bus.steps); end
  endtask

  task automatic test_abort();
    bus.a     = 32'h2E2E2E2E;
    bus.b     = 32'h2E2E2E2E;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_run: got %b want 1", bus.busy); end
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b want 0", bus.busy); end
    begin
      int nd;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
        if (bus.done) nd++;
        @(posedge clk);
        @(negedge clk);
      end
      n_tests++; if (nd != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
    end
    n_tests++; if ({bus.eq, bus.gt} !== 2'b01) begin n_fail++; $display("FAIL abort_keep_eqgt: got %b want 01", {bus.eq, bus.gt}); end
    n_tests++; if (bus.steps !== 3'd1) begin n_fail++; $display("FAIL abort_keep_steps: got %0d want 1", bus.steps); end
  endtask

  task automatic test_lsb_and_mid();
    int lat, nd;
    run_cmp(32'h12345601, 32'h12345602, lat, nd);
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL lsb_latency: got %0d want 5", lat); end
    n_tests++; if ({bus.eq, bus.gt} !== 2'b00) begin n_fail++; $display("FAIL lsb_eqgt: got %b want 00", {bus.eq, bus.gt}); end
    n_tests++; if (bus.steps !== 3'd4) begin n_fail++; $display("FAIL lsb_steps: got %0d want 4", bus.steps); end
    run_cmp(32'h12AA0000, 32'h12550000, lat, nd);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL mid_latency: got %0d want 3", lat); end
    n_tests++; if ({bus.eq, bus.gt} !== 2'b01) begin n_fail++; $display("FAIL mid_eqgt: got %b want 01", {bus.eq, bus.gt}); end
    n_tests++; if (bus.steps !== 3'd2) begin n_fail++; $display("FAIL mid_steps: got %0d want 2", bus.steps); end
  endtask

  task automatic test_start_ignored();
    int lat, nd;
    bus.a     = 32'h55555555;
    bus.b     = 32'h55555555;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'h00000000;
    lat = 0;
    nd  = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (lat == 0) lat = i;
      end
    end
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL ignore_latency: got %0d want 5", lat); end
    n_tests++; if (nd != 1) begin n_fail++; $display("FAIL ignore_ndone: got %0d want 1", nd); end
    n_tests++; if ({bus.eq, bus.gt} !== 2'b10) begin n_fail++; $display("FAIL ignore_eqgt: got %b want 10", {bus.eq, bus.gt}); end
    n_tests++; if (bus.steps !== 3'd4) begin n_fail++; $display("FAIL ignore_steps: got %0d want 4", bus.steps); end
  endtask

  task automatic test_async_reset();
    int lat, nd;
    bus.a     = 32'h2E2E2E2E;
    bus.b     = 32'h2E2E2E2E;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", bus.busy); end
    n_tests++; if ({bus.eq, bus.gt} !== 2'b10) begin n_fail++; $display("FAIL areset_eqgt: got %b want 10", {bus.eq, bus.gt}); end
    n_tests++; if (bus.steps !== 3'd0) begin n_fail++; $display("FAIL areset_steps: got %0d want 0", bus.steps); end
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    n_tests++; if (nd != 0) begin n_fail++; $display("FAIL areset_no_done: got %0d pulses want 0", nd); end
    run_cmp(32'h00000100, 32'h00000200, lat, nd);
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 4", lat); end
    n_tests++; if (nd != 1) begin n_fail++; $display("FAIL post_reset_ndone: got %0d want 1", nd); end
    n_tests++; if ({bus.eq, bus.gt} !== 2'b00) begin n_fail++; $display("FAIL post_reset_eqgt: got %b want 00", {bus.eq, bus.gt}); end
    n_tests++; if (bus.steps !== 3'd3) begin n_fail++; $display("FAIL post_reset_steps: got %0d want 3", bus.steps); end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_equal();
    test_msb_early();
    test_abort();
    test_lsb_and_mid();
    test_start_ignored();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
